// File: rtl/cpu_run_pkg.sv
// Shared state and mode encodings for the CPU run/step controller.
package cpu_run_pkg;

    localparam logic [1:0] HALT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STEP  = 2'd2;
    localparam logic [1:0] BREAK = 2'd3;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HALT = 2'b11;

    function automatic logic is_run_mode(input logic [1:0] mode);
        return (mode == MODE_RUN) || (mode == MODE_SLOW);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-input / CPU-status bundle for cpu_run_ctrl; slave is the controller side.
// Level signals only, no handshake: outputs are valid every cycle.
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);

    logic              btn_step;
    logic [1:0]        mode_sel;
    logic [PC_W-1:0]   pc;
    logic              bp_en;
    logic [PC_W-1:0]   bp_addr;
    logic              cpu_ce;
    logic              halted;
    logic [1:0]        state;
    logic [CNT_W-1:0]  step_count;

    modport master (
        output btn_step, mode_sel, pc, bp_en, bp_addr,
        input  cpu_ce, halted, state, step_count
    );

    modport slave (
        input  btn_step, mode_sel, pc, bp_en, bp_addr,
        output cpu_ce, halted, state, step_count
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce, rising-edge pulse.
// Latency from a clean press to rise is 2+DEBOUNCE_CYCLES cycles; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // rise is registered on the same edge as the level flip, so it is not delayed a cycle behind level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller producing the CPU clock-enable; PC breakpoint built only with CPU_RUN_BP_EN.
// cpu_ce is combinational from registered state (no extra latency); step presses in RUN/STEP are dropped.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int PC_W            = 32,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000,
    parameter int CNT_W           = 16
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int             DIV_W    = $clog2(RUN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [1:0]        r_state;
    logic              r_halted;
    logic [DIV_W-1:0]  r_div;
    logic [CNT_W-1:0]  r_step_count;

    logic [1:0]        w_state_nxt;
    logic              w_step_req;
    logic              w_unused_level;
    logic              w_bp_hit;
    logic              w_tick;
    logic              w_cpu_ce;
    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_bp_addr;

    assign w_pc      = bus.pc;
    assign w_bp_addr = bus.bp_addr;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (bus.btn_step),
        .level  (w_unused_level),
        .rise   (w_step_req)
    );

`ifdef CPU_RUN_BP_EN
    assign w_bp_hit = bus.bp_en & (w_pc == w_bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bus.bp_en, w_pc, w_bp_addr};
    assign w_bp_hit    = 1'b0;
`endif

    always_comb begin
        w_tick = 1'b0;
        case (bus.mode_sel)
            MODE_RUN:  w_tick = 1'b1;
            MODE_SLOW: w_tick = (r_div == DIV_LAST);
            default:   w_tick = 1'b0;
        endcase
    end

    // Reset gates the enable so the CPU never advances in a reset cycle
    assign w_cpu_ce = ~rst & (((r_state == RUN) & w_tick & ~w_bp_hit) | (r_state == STEP));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HALT: begin
                if (is_run_mode(bus.mode_sel)) begin
                    w_state_nxt = RUN;
                end else if ((bus.mode_sel == MODE_STEP) && w_step_req) begin
                    w_state_nxt = STEP;
                end
            end
            RUN: begin
                if (!is_run_mode(bus.mode_sel)) begin
                    w_state_nxt = HALT;
                end else if (w_bp_hit) begin
                    w_state_nxt = BREAK;
                end
            end
            STEP: begin
                w_state_nxt = is_run_mode(bus.mode_sel) ? RUN : HALT;
            end
            BREAK: begin
                if (bus.mode_sel == MODE_HALT) begin
                    w_state_nxt = HALT;
                end else if (w_step_req) begin
                    w_state_nxt = STEP;
                end
            end
            default: w_state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HALT;
            r_halted     <= 1'b1;
            r_div        <= '0;
            r_step_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == HALT) | (w_state_nxt == BREAK);
            // Every entry into RUN restarts the slow-run period from zero
            if ((w_state_nxt == RUN) && (r_state != RUN)) begin
                r_div <= '0;
            end else if ((r_state == RUN) && (bus.mode_sel == MODE_SLOW)) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            end
            if (w_cpu_ce) begin
                r_step_count <= r_step_count + 1'b1;
            end
        end
    end

    assign bus.cpu_ce     = w_cpu_ce;
    assign bus.halted     = r_halted;
    assign bus.state      = r_state;
    assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed scenarios plus randomized traffic for cpu_run_ctrl, checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int DEB   = 4;
    localparam int RDIV  = 5;

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

`ifdef CPU_RUN_BP_EN
    localparam bit BP_FEATURE = 1'b1;
`else
    localparam bit BP_FEATURE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(
        .PC_W            (PC_W),
        .DEBOUNCE_CYCLES (DEB),
        .RUN_DIV         (RDIV),
        .CNT_W           (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    bit          last_ce  = 1'b0;
    bit          saw_break = 1'b0;
    bit          chk_en   = 1'b0;
    logic [31:0] pc_r     = 32'h0;

    // Behavioural reference: state by rule table, debounce as a sliding window of synced samples
    logic [1:0]  m_state  = S_HALT;
    int          m_count  = 0;
    bit          m_level  = 1'b0;
    bit          m_rise   = 1'b0;
    int          m_slow_n = 0;
    bit          raw_q[$];
    bit          win_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_bp();
        return BP_FEATURE && bus.bp_en && (bus.pc == bus.bp_addr);
    endfunction

    function automatic bit m_tick();
        if (bus.mode_sel == 2'b00) return 1'b1;
        if (bus.mode_sel == 2'b01) return ((m_slow_n + 1) % RDIV) == 0;
        return 1'b0;
    endfunction

    function automatic bit m_ce();
        if (rst) return 1'b0;
        if (m_state == S_STEP) return 1'b1;
        return (m_state == S_RUN) && m_tick() && !m_bp();
    endfunction

    task automatic model_edge();
        logic [1:0] nxt;
        bit req, d, all_diff, run_mode, ce_now;
        if (rst) begin
            m_state  = S_HALT;
            m_count  = 0;
            m_level  = 1'b0;
            m_rise   = 1'b0;
            m_slow_n = 0;
            raw_q.delete();
            raw_q.push_back(1'b0);
            raw_q.push_back(1'b0);
            win_q.delete();
            return;
        end
        ce_now   = m_ce();
        req      = m_rise;
        run_mode = (bus.mode_sel == 2'b00) || (bus.mode_sel == 2'b01);
        nxt      = m_state;
        case (m_state)
            S_HALT:  if (run_mode) nxt = S_RUN;
                     else if (bus.mode_sel == 2'b10 && req) nxt = S_STEP;
            S_RUN:   if (!run_mode) nxt = S_HALT;
                     else if (m_bp()) nxt = S_BREAK;
            S_STEP:  nxt = run_mode ? S_RUN : S_HALT;
            default: if (bus.mode_sel == 2'b11) nxt = S_HALT;
                     else if (req) nxt = S_STEP;
        endcase
        if (ce_now) m_count = (m_count + 1) & 32'hFFFF;
        if (nxt == S_RUN && m_state != S_RUN) m_slow_n = 0;
        else if (m_state == S_RUN && bus.mode_sel == 2'b01) m_slow_n++;
        m_state = nxt;
        // Button: the debouncer sees the raw level from two edges earlier
        raw_q.push_back(bus.btn_step);
        d = raw_q.pop_front();
        m_rise = 1'b0;
        win_q.push_back(d);
        if (win_q.size() > DEB) void'(win_q.pop_front());
        all_diff = (win_q.size() == DEB);
        foreach (win_q[i]) if (win_q[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = !m_level;
            m_rise  = m_level;
            win_q.delete();
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) begin
            chk("state", 32'(bus.state), 32'(m_state));
            chk("halted", 32'(bus.halted), 32'(m_state == S_HALT || m_state == S_BREAK));
            chk("step_count", 32'(bus.step_count), 32'(m_count));
            chk("cpu_ce", 32'(bus.cpu_ce), 32'(m_ce()));
        end
        last_ce = bus.cpu_ce;
        if (bus.state == S_BREAK) saw_break = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        if (last_ce) begin
            pulses++;
            pc_r  += 32'd4;
            bus.pc = pc_r;
        end
    endtask

    task automatic do_reset(input logic [1:0] mode, input int n);
        rst          = 1'b1;
        bus.mode_sel = mode;
        bus.btn_step = 1'b0;
        pc_r         = 32'h0;
        bus.pc       = 32'h0;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    int btn_hold = 0;

    initial begin
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        rst          = 1'b1;
        bus.mode_sel = 2'b00;
        bus.btn_step = 1'b0;
        bus.pc       = 32'h0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 32'h0;

        // Reset held 3 cycles, then free-run
        cycle();
        chk_en = 1'b1;
        cycle();
        cycle();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd1);
        chk("rst_ce", 32'(bus.cpu_ce), 32'd0);
        chk("rst_count", 32'(bus.step_count), 32'd0);
        rst = 1'b0;
        cycle();
        chk("run_after_rst", 32'(bus.state), 32'(S_RUN));
        pulses = 0;
        repeat (6) cycle();
        chk("free_run_pulses", 32'(pulses), 32'd6);

        // Breakpoint at 0x10
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        do_reset(2'b00, 2);
        saw_break = 1'b0;
        pulses    = 0;
        repeat (12) cycle();
`ifdef CPU_RUN_BP_EN
        chk("bp_pulses", 32'(pulses), 32'd4);
        chk("bp_state", 32'(bus.state), 32'(S_BREAK));
        chk("bp_pc", pc_r, 32'h10);
        chk("bp_count", 32'(bus.step_count), 32'd4);
        bus.btn_step = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20 && bus.state != S_STEP; i++) cycle();
        chk("bp_step_seen", 32'(bus.state), 32'(S_STEP));
        chk("bp_step_ce", 32'(bus.cpu_ce), 32'd1);
        chk("bp_no_early", 32'(pulses), 32'd0);
        cycle();
        chk("bp_back_run", 32'(bus.state), 32'(S_RUN));
        chk("bp_step_pc", pc_r, 32'h14);
        chk("bp_step_count", 32'(bus.step_count), 32'd5);
`else
        chk("nobp_pulses", 32'(pulses), 32'd11);
        chk("nobp_break", 32'(saw_break), 32'd0);
        chk("nobp_pc_past", 32'(pc_r > 32'h10), 32'd1);
        chk("nobp_state", 32'(bus.state), 32'(S_RUN));
`endif
        bus.btn_step = 1'b0;
        bus.mode_sel = 2'b11;
        repeat (8) cycle();

        // Slow-run: pulses every RDIV cycles after RUN entry
        bus.bp_en = 1'b0;
        do_reset(2'b01, 2);
        cycle();
        for (int k = 1; k <= 17; k++) begin
            cycle();
            chk("slow_ce", 32'(last_ce), 32'((k % RDIV) == 0));
        end
        bus.mode_sel = 2'b11;
        pulses = 0;
        cycle();
        chk("slow_halt", 32'(bus.state), 32'(S_HALT));
        repeat (10) cycle();
        chk("slow_halt_pulses", 32'(pulses), 32'd0);

        // Single-step with a bouncing button
        do_reset(2'b10, 2);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.btn_step = ((i / 2) % 2) == 0;
            cycle();
        end
        bus.btn_step = 1'b1;
        repeat (12) cycle();
        chk("step_one_pulse", 32'(pulses), 32'd1);
        chk("step_one_count", 32'(bus.step_count), 32'd1);
        chk("step_halt", 32'(bus.state), 32'(S_HALT));
        repeat (10) cycle();
        chk("step_hold_pulses", 32'(pulses), 32'd1);
        bus.btn_step = 1'b0;
        repeat (8) cycle();

        // Reset in the middle of a run
        do_reset(2'b00, 2);
        for (int i = 0; i < 30 && bus.step_count != 16'd7; i++) cycle();
        chk("mid_count7", 32'(bus.step_count), 32'd7);
        rst = 1'b1;
        #2;
        chk("mid_rst_ce", 32'(bus.cpu_ce), 32'd0);
        cycle();
        chk("mid_rst_state", 32'(bus.state), 32'd0);
        chk("mid_rst_count", 32'(bus.step_count), 32'd0);
        rst = 1'b0;

        // Randomized modes, button levels, breakpoints and occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 29) == 0) bus.mode_sel = 2'($urandom_range(0, 3));
            if (btn_hold == 0) begin
                bus.btn_step = 1'($urandom_range(0, 1));
                btn_hold     = $urandom_range(1, 9);
            end else begin
                btn_hold--;
            end
            if ($urandom_range(0, 49) == 0) begin
                bus.bp_en   = 1'($urandom_range(0, 1));
                bus.bp_addr = pc_r + 32'(4 * $urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller that sequences the CPU core by generating its clock-enable.
- Replaces the divided-clock and button-clock muxing with a single-clock enable scheme.
- Modes: free-run, slow-run (divided tick), single-step from a raw push-button, and halt, plus an optional PC breakpoint.
- Sits between the board inputs (button, mode switches) and the CPU; exports status for the 7-segment and LED debug outputs.

Parameters:
- PC_W, 32, width of pc and bp_addr.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level.
- RUN_DIV, 50000000, clk cycles per enable pulse in slow-run mode (must be ≥1).
- CNT_W, 16, width of step_count.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_step  in  1  raw, asynchronous, bouncing step button.
- mode_sel  in  2  00 free-run, 01 slow-run, 10 single-step, 11 halt.
- pc  in  PC_W  current CPU PC; updates only after an edge where cpu_ce=1.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_W  breakpoint PC.
- cpu_ce  out  1  CPU advances one instruction at the clk edge where this is 1 (combinational from registered state).
- halted  out  1  registered; 1 in HALT or BREAK.
- state  out  2  registered FSM state: HALT=0, RUN=1, STEP=2, BREAK=3.
- step_count  out  CNT_W  number of cpu_ce pulses, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=HALT, halted=1, cpu_ce=0, step_count=0. Synchronizer flops, debounced level, debounce counter and divider all reset to 0.
- Reset asserted mid-operation has the same effect at the next edge; no CPU enable pulse occurs in the reset cycle.
- Button path:
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments; at DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - step_req is a 1-cycle pulse on the debounced 0→1 transition.
  - Minimum latency from a clean press to step_req is 2+DEBOUNCE_CYCLES cycles.
- tick:
  - mode_sel=00: tick=1 every cycle.
  - mode_sel=01: divider counts 0..RUN_DIV-1 and tick=1 when count==RUN_DIV-1, then wraps to 0.
  - The divider clears on every entry into RUN.
- bp_hit = bp_en & (pc==bp_addr).
- cpu_ce = (state==RUN & tick & !bp_hit) | (state==STEP).
- Transitions (evaluated every edge, priority top-down within each state):
  - HALT: mode_sel∈{00,01} → RUN; mode_sel=10 & step_req → STEP; else stay.
  - RUN: mode_sel∈{10,11} → HALT; bp_hit → BREAK; else stay. A mode change wins over a simultaneous bp_hit.
  - STEP: lasts exactly one cycle. Then → RUN if mode_sel∈{00,01}, else → HALT. The breakpoint is ignored in STEP, so a step can move past the breakpoint PC.
  - BREAK: mode_sel=11 → HALT; step_req → STEP; else stay. Changing between 00/01/10 does not leave BREAK.
- step_req is ignored in RUN and in STEP.
- A step_req that arrives while the FSM is in a state that ignores it is lost, not queued.
- step_count increments on every edge where cpu_ce=1.
- halted mirrors state∈{HALT, BREAK}, registered alongside state.

Optional Feature:
CPU_RUN_BP_EN.
- Defined: breakpoint logic as above.
- Undefined: bp_hit is tied to 0, bp_en and bp_addr are unused, and BREAK is unreachable. The state encoding is unchanged.

Decomposition:
- Package cpu_run_pkg holds:
  - state encodings HALT/RUN/STEP/BREAK as 2-bit localparams;
  - mode encodings MODE_RUN=00, MODE_SLOW=01, MODE_STEP=10, MODE_HALT=11.
- One sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst, btn_in, level, rise). It contains the synchronizer, debounce counter and edge detector.
- FSM, divider and counter stay in cpu_run_ctrl.

Test Plan:
1. Reset: hold rst 3 cycles with mode_sel=00 → state=0, halted=1, cpu_ce=0, step_count=0. After release: state=1 next edge and cpu_ce=1 every cycle.
2. Breakpoint: DEBOUNCE_CYCLES=4, mode 00, bp_en=1, bp_addr=0x10, pc model +4 per cpu_ce from 0 → exactly 4 pulses, then state=3 with pc=0x10 and step_count=4. A clean press then gives exactly one pulse (pc→0x14) and a return to RUN.
3. Slow-run: RUN_DIV=5, mode 01 → cpu_ce high on cycles 5, 10, 15 after entering RUN. Switching to mode 11 mid-count gives HALT next edge with no further pulses.
4. Single-step: mode 10, DEBOUNCE_CYCLES=4. Button toggles 1/0 every 2 cycles for 20 cycles, then a steady high → exactly one cpu_ce pulse, step_count=1. Holding the button high yields no further pulses.
5. Reset mid-run: rst asserted while in RUN with step_count=7 → next edge state=0, step_count=0, cpu_ce=0 during the reset cycle.
6. With CPU_RUN_BP_EN undefined: repeat scenario 2 → state never reaches 3 and pulses continue past pc=0x10.
